// File: rtl/fu_scheduler.sv
// Sequences a small stored program of functional-unit starts and gives the
// selected FU exclusive use of the shared vector memory port for its step.
`timescale 1ns/1ps

module fu_scheduler #(
    parameter int NUM_FU     = 4,
    parameter int PROG_DEPTH = 8,
    parameter int ADDR_W     = 8,   // width of DI_t
    parameter int DATA_W     = 16   // width of fixed_point_t
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    input  logic                          prog_we_i,
    input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr_i,
    input  logic [$clog2(NUM_FU):0]       prog_data_i,
    output logic [NUM_FU-1:0]             fu_valid_o,
    input  logic [NUM_FU-1:0]             fu_ready_i,
    input  logic [NUM_FU-1:0]             fu_w_en_i,
    input  logic [ADDR_W-1:0]             fu_w_addr_i [NUM_FU],
    input  logic [DATA_W-1:0]             fu_w_data_i [NUM_FU],
    input  logic [ADDR_W-1:0]             fu_r_addr_i [NUM_FU],
    output logic [DATA_W-1:0]             fu_r_data_o,
    output logic                          mem_w_en_o,
    output logic [ADDR_W-1:0]             mem_w_addr_o,
    output logic [DATA_W-1:0]             mem_w_data_o,
    output logic [ADDR_W-1:0]             mem_r_addr_o,
    input  logic [DATA_W-1:0]             mem_r_data_i
);

    localparam int IDX_W = $clog2(NUM_FU);
    localparam int IDX_N = IDX_W + 1;
    localparam int PC_W  = $clog2(PROG_DEPTH);
    localparam logic [IDX_W:0]  FU_LIMIT = IDX_N'(NUM_FU);
    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(PROG_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PC_W-1:0]   pc;
    logic [IDX_W-1:0]  sel;
    logic              last;
    logic [IDX_W:0]    prog_mem [PROG_DEPTH];
    logic [IDX_W:0]    entry;
    logic              sel_ready;
    logic              start_acc;
    logic              fetch_err;
    logic              step_end;
    logic              run_end;
    logic              active;

    assign entry     = prog_mem[pc];
    assign sel_ready = fu_ready_i[sel];

    // NOTE: the program store has no reset; its contents must survive rst_i,
    // and leaving it out of the reset path keeps it mappable to plain RAM.
    always_ff @(posedge clk_i) begin
        if (prog_we_i && state == IDLE) begin
            prog_mem[prog_addr_i] <= prog_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        fetch_err = 1'b0;
        step_end  = 1'b0;
        run_end   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if ({1'b0, entry[IDX_W-1:0]} >= FU_LIMIT) begin
                    fetch_err = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE:     if (sel_ready)  state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!sel_ready) state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (sel_ready) begin
                    if (last || pc == PC_LAST) begin
                        run_end   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        step_end  = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc     <= '0;
            sel    <= '0;
            last   <= 1'b0;
            err_o  <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= fetch_err | run_end;
            if (start_acc) begin
                pc    <= '0;
                err_o <= 1'b0;
            end else if (step_end) begin
                pc <= pc + PC_W'(1);
            end
            if (state == FETCH) begin
                sel  <= entry[IDX_W-1:0];
                last <= entry[IDX_W];
            end
            if (fetch_err) begin
                err_o <= 1'b1;
            end
        end
    end

    // The selected FU owns the memory port from ISSUE until its step ends.
    always_comb begin
        busy_o = (state != IDLE);
        active = (state == ISSUE) || (state == WAIT_BUSY) || (state == WAIT_DONE);
        for (int i = 0; i < NUM_FU; i++) begin
            fu_valid_o[i] = (state == ISSUE) && (sel == IDX_W'(i));
        end
        mem_w_en_o   = active && fu_w_en_i[sel];
        mem_w_addr_o = fu_w_addr_i[sel];
        mem_w_data_o = fu_w_data_i[sel];
        mem_r_addr_o = fu_r_addr_i[sel];
        fu_r_data_o  = mem_r_data_i;
    end

endmodule

// File: tb/tb_fu_scheduler.sv
// Scoreboard bench for fu_scheduler: stimulus queues expected handshakes,
// memory writes and done pulses; a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_fu_scheduler;

    localparam int NF = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    typedef enum logic [1:0] {EV_HS, EV_WR, EV_DONE} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc_cnt = 0;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy, done, err;
    logic          prog_we;
    logic [2:0]    prog_addr;
    logic [2:0]    prog_data;
    logic [NF-1:0] fu_valid, fu_ready, fu_w_en;
    logic [AW-1:0] fu_w_addr [NF];
    logic [DW-1:0] fu_w_data [NF];
    logic [AW-1:0] fu_r_addr [NF];
    logic [DW-1:0] fu_r_data;
    logic          mem_w_en;
    logic [AW-1:0] mem_w_addr, mem_r_addr;
    logic [DW-1:0] mem_w_data, mem_r_data;

    // Second instance with five FUs so an out-of-range index (5) is encodable.
    logic          e_start, e_we, e_busy, e_done, e_err, e_valid_seen;
    logic [2:0]    e_addr;
    logic [3:0]    e_data;
    logic [4:0]    e_valid, e_ready, e_w_en;
    logic [AW-1:0] e_w_addr [5];
    logic [DW-1:0] e_w_data [5];
    logic [AW-1:0] e_r_addr [5];
    logic [DW-1:0] e_r_data, e_mw_data, e_mr_data;
    logic          e_mw_en;
    logic [AW-1:0] e_mw_addr, e_mr_addr;

    int            busy_cnt [NF];
    logic [NF-1:0] force_low;
    logic [NF-1:0] hs_seen;

    fu_scheduler #(.NUM_FU(NF), .PROG_DEPTH(8), .ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
        .err_o(err), .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_data_i(prog_data),
        .fu_valid_o(fu_valid), .fu_ready_i(fu_ready), .fu_w_en_i(fu_w_en),
        .fu_w_addr_i(fu_w_addr), .fu_w_data_i(fu_w_data), .fu_r_addr_i(fu_r_addr),
        .fu_r_data_o(fu_r_data), .mem_w_en_o(mem_w_en), .mem_w_addr_o(mem_w_addr),
        .mem_w_data_o(mem_w_data), .mem_r_addr_o(mem_r_addr), .mem_r_data_i(mem_r_data)
    );

    fu_scheduler #(.NUM_FU(5), .PROG_DEPTH(8), .ADDR_W(AW), .DATA_W(DW)) u_dut_err (
        .clk_i(clk), .rst_i(rst), .start_i(e_start), .busy_o(e_busy), .done_o(e_done),
        .err_o(e_err), .prog_we_i(e_we), .prog_addr_i(e_addr), .prog_data_i(e_data),
        .fu_valid_o(e_valid), .fu_ready_i(e_ready), .fu_w_en_i(e_w_en),
        .fu_w_addr_i(e_w_addr), .fu_w_data_i(e_w_data), .fu_r_addr_i(e_r_addr),
        .fu_r_data_o(e_r_data), .mem_w_en_o(e_mw_en), .mem_w_addr_o(e_mw_addr),
        .mem_w_data_o(e_mw_data), .mem_r_addr_o(e_mr_addr), .mem_r_data_i(e_mr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic void expect_ev(input kind_e k, input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back('{kind: k, a: a, b: b});
    endfunction

    task automatic sb_compare(input kind_e k, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_%s: unexpected event a=%0h b=%0h", k.name(), a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a !== a || e.b !== b) begin
                bad++;
                $display("FAIL sb_%s: got %s a=%0h b=%0h expected %s a=%0h b=%0h",
                         k.name(), k.name(), a, b, e.kind.name(), e.a, e.b);
            end
        end
    endtask

    // Monitor: fixed per-cycle order handshake, write, done.
    initial forever begin
        @(negedge clk);
        if ((fu_valid & fu_ready) != '0) sb_compare(EV_HS, 32'(fu_valid & fu_ready), 32'h0);
        if (mem_w_en === 1'b1) sb_compare(EV_WR, 32'(mem_w_addr), 32'(mem_w_data));
        if (done === 1'b1) sb_compare(EV_DONE, 32'(err), 32'h0);
    end

    initial begin
        e_valid_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (e_valid !== 5'b0 && !rst) e_valid_seen = 1'b1;
        end
    end

    // FU models: ready idles high, drops for 5 cycles after each handshake.
    initial begin
        fu_ready  = '1;
        force_low = '0;
        for (int i = 0; i < NF; i++) busy_cnt[i] = 0;
        forever begin
            @(negedge clk);
            hs_seen = fu_valid & fu_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NF; i++) begin
                if (hs_seen[i]) busy_cnt[i] = 5;
                else if (busy_cnt[i] > 0) busy_cnt[i]--;
                fu_ready[i] = (busy_cnt[i] == 0) && !force_low[i];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic prog_write(input int addr, input logic [2:0] data);
        prog_we   = 1'b1;
        prog_addr = 3'(addr);
        prog_data = data;
        tick(1);
        prog_we   = 1'b0;
    endtask

    task automatic start_run(output int t0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        t0 = cyc_cnt;
    endtask

    task automatic wait_idle(input int t0, input int budget, output int cycles);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        check("run_timeout", 32'(busy), 32'h0);
        cycles = cyc_cnt - t0;
    endtask

    initial begin
        int t0, cyc;
        rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        fu_w_en = '0; mem_r_data = 16'h1234;
        for (int i = 0; i < NF; i++) begin
            fu_w_addr[i] = '0; fu_w_data[i] = '0; fu_r_addr[i] = AW'(8'h20 + i);
        end
        e_start = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0;
        e_ready = '1; e_w_en = '0; e_mr_data = '0;
        for (int i = 0; i < 5; i++) begin
            e_w_addr[i] = '0; e_w_data[i] = '0; e_r_addr[i] = '0;
        end
        fu_w_en[0] = 1'b1;
        tick(2);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_valid", 32'(fu_valid), 0);
        check("idle_w_en", 32'(mem_w_en), 0);
        check("r_data_idle", 32'(fu_r_data), 32'h1234);
        fu_w_en[0] = 1'b0;
        rst = 1'b0;
        tick(1);

        // Two-step program FU1 then FU0(last); FU2 write enable must be ignored.
        prog_write(0, 3'b001);
        prog_write(1, 3'b100);
        expect_ev(EV_HS, 32'h2, 0);
        expect_ev(EV_WR, 32'h03, 32'h0040);
        expect_ev(EV_HS, 32'h1, 0);
        expect_ev(EV_DONE, 32'h0, 0);
        fu_w_en[2] = 1'b1; fu_w_addr[2] = 8'h07; fu_w_data[2] = 16'hBEEF;
        start_run(t0);
        check("busy_run", 32'(busy), 1);
        tick(1);
        check("issue_fu1", 32'(fu_valid), 32'h2);
        check("r_addr_mux", 32'(mem_r_addr), 32'h21);
        fu_w_en[1] = 1'b1; fu_w_addr[1] = 8'h03; fu_w_data[1] = 16'h0040;
        mem_r_data = 16'hA5A5;
        #1;
        check("r_data_run", 32'(fu_r_data), 32'hA5A5);
        tick(1);
        fu_w_en[1] = 1'b0;
        wait_idle(t0, 200, cyc);
        check("two_step_cycles", 32'(cyc), 16);
        fu_w_en[2] = 1'b0;

        // Invalid FU index aborts with err and done; next start clears err.
        e_we = 1'b1; e_addr = 3'd0; e_data = 4'b0101;
        tick(1);
        e_we = 1'b0; e_start = 1'b1;
        tick(1);
        e_start = 1'b0;
        check("err_fetch_busy", 32'(e_busy), 1);
        tick(1);
        check("err_set", 32'(e_err), 1);
        check("err_done", 32'(e_done), 1);
        check("err_idle", 32'(e_busy), 0);
        tick(1);
        check("err_done_pulse", 32'(e_done), 0);
        check("err_sticky", 32'(e_err), 1);
        e_start = 1'b1;
        tick(1);
        e_start = 1'b0;
        check("err_clear", 32'(e_err), 0);
        tick(2);

        // No last flag: all eight entries run; entry 0 write while busy ignored.
        for (int i = 0; i < 8; i++) begin
            prog_write(i, 3'(i % 4));
            expect_ev(EV_HS, 32'(1 << (i % 4)), 0);
        end
        expect_ev(EV_DONE, 32'h0, 0);
        start_run(t0);
        prog_write(0, 3'b111);
        wait_idle(t0, 300, cyc);
        check("eight_step_cycles", 32'(cyc), 64);

        // FU0 stalls in ISSUE, then reset lands in WAIT_DONE with no done.
        expect_ev(EV_HS, 32'h1, 0);
        @(negedge clk);
        force_low[0] = 1'b1;
        tick(1);
        start_run(t0);
        tick(1);
        check("issue_hold_a", 32'(fu_valid), 32'h1);
        tick(2);
        check("issue_hold_b", 32'(fu_valid), 32'h1);
        @(negedge clk);
        force_low[0] = 1'b0;
        tick(4);
        check("wait_done_busy", 32'(busy), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(fu_valid), 0);
        check("abort_done", 32'(done), 0);
        tick(8);

        // Same-cycle write and start; start while busy ignored.
        expect_ev(EV_HS, 32'h8, 0);
        expect_ev(EV_DONE, 32'h0, 0);
        prog_we = 1'b1; prog_addr = 3'd0; prog_data = 3'b111; start = 1'b1;
        tick(1);
        prog_we = 1'b0; start = 1'b0;
        t0 = cyc_cnt;
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle(t0, 100, cyc);
        check("write_start_cycles", 32'(cyc), 8);
        tick(3);
        check("start_ignored", 32'(busy), 0);

        check("sb_drained", 32'(exp_q.size()), 0);
        check("err_dut_valid", 32'(e_valid_seen), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
